// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: default geometry and the lane-slice
// offset helper used by the SA, this collector and the writeback stage.
package sa_pkg;

  localparam int PE_SIZE_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  // Product of two DATA_WIDTH operands plus accumulation headroom.
  localparam int PSUM_WIDTH_DEF = 2 * DATA_WIDTH_DEF + 16;

  // Lane 0 sits in the most significant slice of a packed row.
  function automatic int lane_base(input int lane, input int pe_size, input int width);
    return width * (pe_size - 1 - lane);
  endfunction

endpackage

// File: rtl/sa_row_fifo.sv
// Aligned-row FIFO: one full psum row per entry. A push while full is
// accepted only when a pop frees a slot at the same edge; a pop while
// empty is ignored. Read data is forced to zero while empty.
module sa_row_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array: written on every accepted push, never reset
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sa_psum_collector.sv
// Systolic-array psum collector: deskews the last PE row (lane j arrives
// j cycles after lane 0), queues aligned rows in sa_row_fifo and hands
// them to writeback over valid/ready. Flags tile completion, dropped rows
// (overflow) and partially-enabled aligned rows (skew error).
// Build option: define SA_PSUM_RELU_EN to rectify every lane (negative -> 0)
// before it is written into the FIFO; otherwise lanes pass bit-exact.
module sa_psum_collector
  import sa_pkg::*;
#(
  parameter int PE_SIZE       = PE_SIZE_DEF,
  parameter int PSUM_WIDTH    = PSUM_WIDTH_DEF,
  parameter int FIFO_DEPTH    = 8,
  parameter int ROWS_PER_TILE = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear_i,
  input  logic [PSUM_WIDTH*PE_SIZE-1:0]   psum_row_i,
  input  logic [PE_SIZE-1:0]              psum_en_row_i,
  output logic [PSUM_WIDTH*PE_SIZE-1:0]   out_row_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            fifo_full_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
  output logic                            tile_done_o,
  output logic                            overflow_o,
  output logic                            skew_err_o
);

  localparam int ROW_W  = PSUM_WIDTH * PE_SIZE;
  localparam int TILE_W = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;

  logic signed [PSUM_WIDTH-1:0] lane_al [PE_SIZE];
  logic [PE_SIZE-1:0]           en_al;
  logic [ROW_W-1:0]             wr_row;
  logic                         push_req;
  logic                         skew_hit;
  logic                         push_ok;
  logic                         pop;
  logic                         full;
  logic                         empty;
  logic [TILE_W-1:0]            tile_cnt;

`ifdef SA_PSUM_RELU_EN
  function automatic logic signed [PSUM_WIDTH-1:0] relu(input logic signed [PSUM_WIDTH-1:0] v);
    return v[PSUM_WIDTH-1] ? '0 : v;
  endfunction
`else
  function automatic logic signed [PSUM_WIDTH-1:0] relu(input logic signed [PSUM_WIDTH-1:0] v);
    return v;
  endfunction
`endif

  // Deskew: lane j is delayed PE_SIZE-1-j cycles so all lanes line up
  for (genvar j = 0; j < PE_SIZE; j++) begin : g_lane
    localparam int D    = PE_SIZE - 1 - j;
    localparam int BASE = lane_base(j, PE_SIZE, PSUM_WIDTH);

    logic signed [PSUM_WIDTH-1:0] lane_in;
    logic                         en_in;

    assign lane_in = psum_row_i[BASE +: PSUM_WIDTH];
    assign en_in   = psum_en_row_i[PE_SIZE-1-j];

    if (D == 0) begin : g_comb
      assign lane_al[j] = lane_in;
      assign en_al[j]   = en_in;
    end else begin : g_dly
      logic signed [PSUM_WIDTH-1:0] data_p [D];
      logic [D-1:0]                 en_p;

      // Per-lane delay line; clear discards anything still in flight
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) data_p[k] <= '0;
          en_p <= '0;
        end else if (clear_i) begin
          for (int k = 0; k < D; k++) data_p[k] <= '0;
          en_p <= '0;
        end else begin
          data_p[0] <= lane_in;
          en_p[0]   <= en_in;
          for (int k = 1; k < D; k++) begin
            data_p[k] <= data_p[k-1];
            en_p[k]   <= en_p[k-1];
          end
        end
      end

      assign lane_al[j] = data_p[D-1];
      assign en_al[j]   = en_p[D-1];
    end
  end

  // ---- aligned row: push decision and write-side rectification ----
  assign push_req = &en_al;
  assign skew_hit = (|en_al) & ~push_req;
  assign pop      = ~empty & out_ready_i;
  assign push_ok  = push_req & (~full | pop) & ~clear_i;

  // Repack aligned lanes into the shared row layout, rectified when enabled
  always_comb begin
    wr_row = '0;
    for (int j = 0; j < PE_SIZE; j++) begin
      wr_row[lane_base(j, PE_SIZE, PSUM_WIDTH) +: PSUM_WIDTH] = relu(lane_al[j]);
    end
  end

  sa_row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_i),
    .push  (push_ok),
    .pop   (pop),
    .wdata (wr_row),
    .rdata (out_row_o),
    .full  (full),
    .empty (empty),
    .count (fifo_count_o)
  );

  assign out_valid_o = ~empty;
  assign fifo_full_o = full;

  // Tile row counter and registered tile-done pulse on the wrapping push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_cnt    <= '0;
      tile_done_o <= 1'b0;
    end else if (clear_i) begin
      tile_cnt    <= '0;
      tile_done_o <= 1'b0;
    end else begin
      tile_done_o <= 1'b0;
      if (push_ok) begin
        if (tile_cnt == TILE_W'(ROWS_PER_TILE - 1)) begin
          tile_cnt    <= '0;
          tile_done_o <= 1'b1;
        end else begin
          tile_cnt <= tile_cnt + 1'b1;
        end
      end
    end
  end

  // Sticky error flags: dropped row and partially-enabled aligned row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
      skew_err_o <= 1'b0;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
      skew_err_o <= 1'b0;
    end else begin
      if (push_req && full && !pop) overflow_o <= 1'b1;
      if (skew_hit)                 skew_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sa_psum_collector.sv
// Directed bench for sa_psum_collector (PE_SIZE=4, PSUM_WIDTH=32, depth 8,
// 4 rows per tile). Rows are fed with the SA skew; expectations are
// hand-built from the stimulus rows.
module tb_sa_psum_collector;

  localparam int PE = 4;
  localparam int PW = 32;

  logic           clk;
  logic           rst_n;
  logic           clear_i;
  logic [PW*PE-1:0] psum_row_i;
  logic [PE-1:0]  psum_en_row_i;
  logic [PW*PE-1:0] out_row_o;
  logic           out_valid_o;
  logic           out_ready_i;
  logic           fifo_full_o;
  logic [3:0]     fifo_count_o;
  logic           tile_done_o;
  logic           overflow_o;
  logic           skew_err_o;

  int checks = 0;
  int errors = 0;

  logic signed [PW-1:0] rows [16][PE];
  logic [PW*PE-1:0]     got [$];
  int                   done_cnt = 0;
  int                   done_idx = -1;

  sa_psum_collector #(
    .PE_SIZE       (PE),
    .PSUM_WIDTH    (PW),
    .FIFO_DEPTH    (8),
    .ROWS_PER_TILE (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_i),
    .psum_row_i    (psum_row_i),
    .psum_en_row_i (psum_en_row_i),
    .out_row_o     (out_row_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .fifo_full_o   (fifo_full_o),
    .fifo_count_o  (fifo_count_o),
    .tile_done_o   (tile_done_o),
    .overflow_o    (overflow_o),
    .skew_err_o    (skew_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted rows and tile-done pulses, sampled mid low phase
  always begin
    @(negedge clk);
    #2;
    if (out_valid_o && out_ready_i) got.push_back(out_row_o);
    if (tile_done_o) begin
      done_cnt++;
      done_idx = got.size();
    end
  end

  task automatic check(input string tag, input logic [PW*PE-1:0] obs, input logic [PW*PE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW*PE-1:0] pack(input int r);
    logic [PW*PE-1:0] v;
    for (int j = 0; j < PE; j++) v[PW*(PE-j)-1 -: PW] = rows[r][j];
    return v;
  endfunction

  task automatic fill_rows(input int base);
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < PE; j++) rows[r][j] = base + 16 * r + j;
  endtask

  // Feed rows first..first+n-1 with lane j delayed j cycles; optionally
  // assert out_ready_i only in the cycle whose edge pushes the last row
  task automatic send_rows(input int first, input int n, input bit ready_last);
    logic [PW*PE-1:0] pr;
    logic [PE-1:0]    pe;
    for (int c = 0; c < n + PE - 1; c++) begin
      @(negedge clk);
      pr = '0;
      pe = '0;
      for (int j = 0; j < PE; j++) begin
        if (c - j >= 0 && c - j < n) begin
          pr[PW*(PE-j)-1 -: PW] = rows[first + c - j][j];
          pe[PE-1-j] = 1'b1;
        end
      end
      psum_row_i    = pr;
      psum_en_row_i = pe;
      if (ready_last && c == n + PE - 2) out_ready_i = 1'b1;
    end
    @(negedge clk);
    psum_row_i    = '0;
    psum_en_row_i = '0;
    if (ready_last) out_ready_i = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  task automatic reset_log();
    #1;
    got.delete();
    done_cnt = 0;
    done_idx = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    clear_i       = 1'b0;
    psum_row_i    = '0;
    psum_en_row_i = '0;
    out_ready_i   = 1'b0;

    // Reset state
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_count", fifo_count_o, 0);
    check("rst_row", out_row_o, 0);
    check("rst_flags", {tile_done_o, overflow_o, skew_err_o, fifo_full_o}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single row: lanes {1,2,3,4}, visible 4 cycles after lane 0
    rows[0][0] = 1; rows[0][1] = 2; rows[0][2] = 3; rows[0][3] = 4;
    send_rows(0, 1, 1'b0);
    check("single_valid", out_valid_o, 1);
    check("single_row", out_row_o, {32'd1, 32'd2, 32'd3, 32'd4});
    check("single_count", fifo_count_o, 1);
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    check("single_popped", {out_valid_o, fifo_count_o}, 0);
    check("empty_row_zero", out_row_o, 0);

    // Tile: clear restarts the count (one row was already counted)
    do_clear();
    out_ready_i = 1'b1;
    fill_rows(16);
    reset_log();
    send_rows(0, 4, 1'b0);
    @(negedge clk);
    out_ready_i = 1'b0;
    check("tile_rows", got.size(), 4);
    for (int r = 0; r < 4; r++) check("tile_row_data", got[r], pack(r));
    check("tile_done_cnt", done_cnt, 1);
    check("tile_done_idx", done_idx, 4);

    // Overflow: 9 rows into depth 8 with no consumer
    do_clear();
    fill_rows(256);
    reset_log();
    send_rows(0, 9, 1'b0);
    check("ovf_full", fifo_full_o, 1);
    check("ovf_count", fifo_count_o, 8);
    check("ovf_flag", overflow_o, 1);
    out_ready_i = 1'b1;
    repeat (8) @(negedge clk);
    out_ready_i = 1'b0;
    check("ovf_drained", {out_valid_o, fifo_count_o}, 0);
    check("ovf_rows", got.size(), 8);
    for (int r = 0; r < 8; r++) check("ovf_order", got[r], pack(r));
    check("ovf_sticky", overflow_o, 1);

    // Reset asserted mid-stream
    send_rows(0, 3, 1'b0);
    check("pre_rst_count", fifo_count_o, 3);
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {out_valid_o, fifo_full_o, fifo_count_o, tile_done_o, overflow_o, skew_err_o}, 0);
    check("async_rst_row", out_row_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", {out_valid_o, fifo_count_o}, 0);

    // Full + simultaneous pop and push
    fill_rows(4096);
    send_rows(0, 8, 1'b0);
    check("fp_full_before", {fifo_full_o, fifo_count_o}, {1'b1, 4'd8});
    send_rows(8, 1, 1'b1);
    check("fp_count", fifo_count_o, 8);
    check("fp_full", fifo_full_o, 1);
    check("fp_no_ovf", overflow_o, 0);
    check("fp_head", out_row_o, pack(1));

    // Skew error: lane 2 enable one cycle late
    do_clear();
    @(negedge clk); psum_en_row_i = 4'b1000; psum_row_i = '1;
    @(negedge clk); psum_en_row_i = 4'b0100;
    @(negedge clk); psum_en_row_i = 4'b0000;
    @(negedge clk); psum_en_row_i = 4'b0011;
    @(negedge clk); psum_en_row_i = 4'b0000; psum_row_i = '0;
    repeat (3) @(negedge clk);
    check("skew_flag", skew_err_o, 1);
    check("skew_no_push", {out_valid_o, fifo_count_o}, 0);
    do_clear();
    check("skew_cleared", {skew_err_o, fifo_count_o}, 0);

    // Lane sign handling
    rows[0][0] = -5; rows[0][1] = 7; rows[0][2] = -1; rows[0][3] = 0;
    send_rows(0, 1, 1'b0);
    check("relu_valid", out_valid_o, 1);
`ifdef SA_PSUM_RELU_EN
    check("relu_row", out_row_o, {32'sd0, 32'sd7, 32'sd0, 32'sd0});
`else
    check("relu_row", out_row_o, {-32'sd5, 32'sd7, -32'sd1, 32'sd0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
